// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA operand FIFO: default geometry and the
// operand triple type (n = modulus, d = private exponent, c = ciphertext).
package rsa_pkg;

  localparam int RSA_WIDTH_DEF = 32;
  localparam int RSA_DEPTH_DEF = 32;

  // Default-width operand triple as seen by the loader and the exponentiation engine.
  typedef struct packed {
    logic [RSA_WIDTH_DEF-1:0] n;
    logic [RSA_WIDTH_DEF-1:0] d;
    logic [RSA_WIDTH_DEF-1:0] c;
  } rsa_triple_t;

endpackage : rsa_pkg

// File: rtl/rsa_fifo_ptr.sv
// Modulo-DEPTH pointer with increment enable, synchronous flush and
// asynchronous active-low reset. DEPTH is a power of two, so the natural
// binary rollover of an AW-bit counter gives the modulo wrap.
module rsa_fifo_ptr #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // Next pointer: flush wins over increment; otherwise hold.
  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + AW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule : rsa_fifo_ptr

// File: rtl/rsa_operand_fifo.sv
// First-word-fall-through FIFO of RSA operand triples between the key/cipher
// loader and the modular-exponentiation engine. All DEPTH slots are usable;
// occupancy is tracked in a separate AW+1 bit counter.
// Optional build macro RSA_FIFO_ERR_EN adds sticky err_overflow/err_underflow.
module rsa_operand_fifo
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH_DEF,
  parameter int DEPTH = RSA_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_n,
  input  logic [WIDTH-1:0] in_d,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_n,
  output logic [WIDTH-1:0] out_d,
  output logic [WIDTH-1:0] out_c,
  output logic [AW:0]      count
`ifdef RSA_FIFO_ERR_EN
  ,
  output logic             err_overflow,
  output logic             err_underflow
`endif
);

  localparam int         CW       = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  // Width-parameterised form of rsa_triple_t (identical layout at default WIDTH).
  typedef struct packed {
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] c;
  } triple_t;

  triple_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          push_s;
  logic          pop_s;
  triple_t       head_s;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign count     = count_q;

  rsa_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (push_s),
    .ptr   (wr_ptr)
  );

  rsa_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (pop_s),
    .ptr   (rd_ptr)
  );

  // Storage write; the triple offered in a flush cycle is discarded. Not reset.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem[wr_ptr] <= '{n: in_n, d: in_d, c: in_c};
    end
  end

  // Occupancy: flush clears; push-only +1, pop-only -1, both or neither hold.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fall-through head data, zeroed whenever the FIFO is empty.
  always_comb begin
    head_s = '0;
    if (out_valid) begin
      head_s = mem[rd_ptr];
    end else begin
      head_s = '0;
    end
  end

  assign out_n = head_s.n;
  assign out_d = head_s.d;
  assign out_c = head_s.c;

`ifdef RSA_FIFO_ERR_EN
  logic err_overflow_q;
  logic err_overflow_d;
  logic err_underflow_q;
  logic err_underflow_d;

  // Sticky protocol-violation flags; only flush (or reset) clears them.
  always_comb begin
    err_overflow_d  = err_overflow_q;
    err_underflow_d = err_underflow_q;
    if (flush) begin
      err_overflow_d  = 1'b0;
      err_underflow_d = 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        err_overflow_d = 1'b1;
      end else begin
        err_overflow_d = err_overflow_q;
      end
      if (out_ready && !out_valid) begin
        err_underflow_d = 1'b1;
      end else begin
        err_underflow_d = err_underflow_q;
      end
    end
  end

  // Error flag registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;
`endif

endmodule : rsa_operand_fifo
